// File: rtl/j0_membridge_pkg.sv
// Shared types and constants for the j0 data-side memory bridge.
package j0_membridge_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned MEM_AW     = 16;
    localparam int unsigned IO_SEL_BIT = 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        RD_DONE = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

endpackage

// File: rtl/j0_membridge.sv
// j0 core data port bridge: stalled shared-RAM reads, posted shared-RAM writes,
// and zero-wait pass-through to the fast I/O register region.
module j0_membridge
    import j0_membridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned IO_AW  = 4
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] mem_din,
    output logic              pause,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [IO_AW-1:0]  io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata
);

    state_t            state;
    state_t            state_n;
    logic              pause_c;
    logic              load_rd;
    logic              load_wr;
    logic              capture;
    logic              io_sel;
    logic              granted;
    logic [DATA_W-1:0] rbuf;

    // Address bits between the RAM window and the region select alias away.
    logic unused_alias_bits;
    assign unused_alias_bits = ^mem_addr[IO_SEL_BIT-1:ADDR_W];

    assign io_sel  = mem_addr[IO_SEL_BIT];
    assign granted = bus_req & bus_gnt;

    // Next state, stall and buffer-load decisions.
    always_comb begin
        state_n = state;
        pause_c = 1'b0;
        load_rd = 1'b0;
        load_wr = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd && !io_sel) begin
                    pause_c = 1'b1;
                    load_rd = 1'b1;
                    state_n = RD_REQ;
                end else if (mem_wr && !io_sel) begin
                    load_wr = 1'b1;
                    state_n = WR_REQ;
                end
            end
            RD_REQ: begin
                pause_c = 1'b1;
                if (granted) state_n = RD_DATA;
            end
            RD_DATA: begin
                pause_c = 1'b1;
                capture = 1'b1;
                state_n = RD_DONE;
            end
            RD_DONE: begin
                // The write half of a read-modify instruction only shows up here.
                if (mem_wr && !io_sel) begin
                    load_wr = 1'b1;
                    state_n = WR_REQ;
                end else begin
                    state_n = IDLE;
                end
            end
            WR_REQ: begin
                pause_c = 1'b1;
                if (granted) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Bus outputs and the read/write buffers; bus_addr/bus_wdata double as wbuf.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rbuf      <= '0;
        end else begin
            bus_req <= (state_n == RD_REQ) || (state_n == WR_REQ);
            bus_we  <= (state_n == WR_REQ);
            if (load_rd || load_wr) bus_addr <= mem_addr[ADDR_W-1:0];
            if (load_wr) bus_wdata <= mem_dout;
            if (capture) rbuf <= bus_rdata;
        end
    end

    assign pause    = sys_rst_n_i & pause_c;
    assign mem_din  = (state == RD_DONE) ? rbuf : io_rdata;
    assign io_rd    = sys_rst_n_i & mem_rd & io_sel;
    assign io_wr    = sys_rst_n_i & mem_wr & io_sel;
    assign io_addr  = mem_addr[IO_AW-1:0];
    assign io_wdata = mem_dout;

endmodule

// File: tb/tb_j0_membridge.sv
// Scoreboard bench for j0_membridge: a core driver, a RAM/arbiter model and
// monitors that check read data and bus transactions as the DUT presents them.
module tb_j0_membridge;

    logic        clk;
    logic        rst_n;
    logic        mem_rd;
    logic        core_wr;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic [15:0] mem_din;
    logic        pause;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        io_rd;
    logic        io_wr;
    logic [3:0]  io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] ram[4096];
    int          gnt_wait;
    int          gcnt;
    int          n_cmp;
    int          n_fail;

    j0_membridge #(.ADDR_W(12), .IO_AW(4)) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .pause      (pause),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .io_rd      (io_rd),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The core gates its own write strobe with pause.
    assign mem_wr    = core_wr & ~pause;
    assign bus_rdata = ram[bus_addr];
    assign bus_gnt   = bus_req && (gcnt >= gnt_wait);

    // Arbiter model: grant after gnt_wait cycles of request; RAM takes writes.
    always @(posedge clk) begin
        if (bus_req && !bus_gnt) gcnt <= gcnt + 1;
        else                     gcnt <= 0;
        if (bus_req && bus_gnt && bus_we) ram[bus_addr] <= bus_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read data at the cycle the core consumes it.
    always @(negedge clk) begin
        if (rst_n && mem_rd && !pause) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read_consume", 32'(mem_din), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = rd_q.pop_front();
                check("mem_din", 32'(mem_din), 32'(e));
            end
        end
    end

    // Monitor: every granted bus cycle against the expected transaction list.
    always @(negedge clk) begin
        if (rst_n && bus_req && bus_gnt) begin
            if (bus_q.size() == 0) begin
                check("unexpected_bus_cycle", {19'd0, bus_we, bus_addr}, 32'hFFFF_FFFF);
            end else begin
                bus_exp_t e;
                e = bus_q.pop_front();
                check("bus_we", 32'(bus_we), 32'(e.we));
                check("bus_addr", 32'(bus_addr), 32'(e.addr));
                if (e.we) check("bus_wdata", 32'(bus_wdata), 32'(e.data));
            end
        end
    end

    // One core instruction: holds its strobes until pause drops, counts stall cycles.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] exp_din, input int wait_c, input int exp_pause);
        int cnt;
        @(posedge clk);
        #1;
        gnt_wait = wait_c;
        mem_rd   = rd;
        core_wr  = wr;
        mem_addr = addr;
        mem_dout = data;
        if (rd) rd_q.push_back(exp_din);
        if (!addr[15]) begin
            if (rd) bus_q.push_back('{we: 1'b0, addr: addr[11:0], data: 16'h0});
            if (wr) bus_q.push_back('{we: 1'b1, addr: addr[11:0], data: data});
        end
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!pause) break;
            cnt++;
            if (cnt > 60) begin
                check({name, "_stall_timeout"}, 32'(cnt), 32'(exp_pause));
                break;
            end
        end
        check({name, "_pause_cycles"}, 32'(cnt), 32'(exp_pause));
        if (addr[15]) begin
            check({name, "_io_rd"}, 32'(io_rd), 32'(rd));
            check({name, "_io_wr"}, 32'(io_wr), 32'(wr));
            check({name, "_io_addr"}, 32'(io_addr), 32'(addr[3:0]));
            if (wr) check({name, "_io_wdata"}, 32'(io_wdata), 32'(data));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        gnt_wait = 0;
        gcnt     = 0;
        io_rdata = 16'h0077;
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0;
        ram[12'h123] = 16'hBEEF;
        ram[12'h010] = 16'h1111;

        // Reset with active strobes: everything must read as idle.
        rst_n    = 1'b1;
        mem_rd   = 1'b1;
        core_wr  = 1'b1;
        mem_addr = 16'h8001;
        mem_dout = 16'h0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_io_rd", 32'(io_rd), 32'd0);
        check("rst_io_wr", 32'(io_wr), 32'd0);
        mem_addr = 16'h0001;
        #1;
        check("rst_pause", 32'(pause), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        mem_rd  = 1'b0;
        core_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        access("rd_0123",   1, 0, 16'h0123, 16'h0, 16'hBEEF, 0, 3);
        access("rd_alias",  1, 0, 16'h1123, 16'h0, 16'hBEEF, 0, 3);
        access("wr_0040",   0, 1, 16'h0040, 16'hA5A5, 16'h0, 3, 0);
        access("nop_wr40",  0, 0, 16'h0000, 16'h0, 16'h0, 3, 4);
        access("rd_0040",   1, 0, 16'h0040, 16'h0, 16'hA5A5, 0, 3);
        access("rmw_0010",  1, 1, 16'h0010, 16'h2222, 16'h1111, 0, 3);
        access("nop_rmw",   0, 0, 16'h0000, 16'h0, 16'h0, 0, 1);
        access("rd_0010",   1, 0, 16'h0010, 16'h0, 16'h2222, 0, 3);
        access("wr_0050",   0, 1, 16'h0050, 16'h5A5A, 16'h0, 0, 0);
        access("rd_0050",   1, 0, 16'h0050, 16'h0, 16'h5A5A, 0, 4);
        access("io_rd_8003", 1, 0, 16'h8003, 16'h0, 16'h0077, 0, 0);
        access("io_wr_8005", 0, 1, 16'h8005, 16'h1234, 16'h0, 0, 0);
        access("rd_wait2",  1, 0, 16'h0123, 16'h0, 16'hBEEF, 2, 5);

        // Reset while the read is waiting for grant.
        @(posedge clk);
        #1;
        gnt_wait = 5;
        mem_rd   = 1'b1;
        core_wr  = 1'b0;
        mem_addr = 16'h0123;
        repeat (2) @(negedge clk);
        check("pre_rst_bus_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus_req", 32'(bus_req), 32'd0);
        check("async_rst_pause", 32'(pause), 32'd0);
        check("async_rst_bus_addr", 32'(bus_addr), 32'd0);
        mem_rd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_mem_din", 32'(mem_din), 32'h0077);
        check("post_rst_bus_req", 32'(bus_req), 32'd0);

        access("rd_after_rst", 1, 0, 16'h0123, 16'h0, 16'hBEEF, 0, 3);
        access("nop_end",      0, 0, 16'h0000, 16'h0, 16'h0, 0, 0);
        repeat (2) @(posedge clk);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
